uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL provide clk  in  1  single system clock, 50 MHz, all logic rising-edge.
REQ-002 SHALL provide reset_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL provide rx  in  1  serial input, idle high.
REQ-004 SHALL provide tx  out  1  serial output, idle high.
REQ-005 SHALL provide addr_o  out  24  bus byte address.
REQ-006 SHALL provide data_write_o  out  16  bus write data.
REQ-007 SHALL provide data_read_i  in  16  bus read data, valid when ack_i high.
REQ-008 SHALL provide ds_o  out  2  data strobes, bit1 upper byte, bit0 lower byte.
REQ-009 SHALL provide rw_o  out  1  1 means read, 0 means write.
REQ-010 SHALL provide req_o  out  1  bus cycle request.
REQ-011 SHALL provide ack_i  in  1  responder acknowledge.
REQ-012 SHALL provide busy  out  1  high whenever the FSM is not in IDLE.
REQ-013 SHALL use parameter TICK, default 434, clocks per bit (50 MHz / 115200).

Function
REQ-014 SHALL frame serial data as 1 start bit (0), 8 data bits LSB first, then 2 stop bits (1) on TX.
REQ-015 SHALL detect a start bit on rx==0 in RX idle, recheck rx at TICK/2, and return to RX idle if rx==1 there.
REQ-016 SHALL sample each data bit and the stop bit at TICK intervals from the start-bit midpoint.
REQ-017 SHALL discard a received byte whose stop bit samples 0, with no effect on the command FSM.
REQ-018 SHALL run the command FSM through states IDLE, ADDR, DATA, BUS, RESP.
REQ-019 SHALL handle each byte in IDLE as: 0x52 'R' -> ADDR (read), 0x57 'W' -> ADDR (write), any other value ignored.
REQ-020 SHALL collect 3 address bytes in ADDR, MSB first, then go to DATA for a write or BUS for a read.
REQ-021 SHALL collect 2 data bytes in DATA, MSB first, then go to BUS.
REQ-022 SHALL abort to IDLE with no bus cycle if ADDR or DATA waits more than 2^20 clocks for a byte.
REQ-023 SHALL, on entry to BUS, drive req_o=1 and ds_o=2'b11, and hold addr_o, rw_o, data_write_o stable until the cycle ends.
REQ-024 SHALL end the bus cycle in the clock ack_i is sampled high, deasserting req_o on the next edge (one-cycle handshake latency).
REQ-025 SHALL latch data_read_i in the same edge that samples ack_i high during a read.
REQ-026 SHALL end the bus cycle if ack_i stays low for 256 clocks after req_o rises, deassert req_o, and flag an error.
REQ-027 SHALL send in RESP: read OK -> 2 bytes (data hi, lo); write OK -> 0x4B; timeout -> single 0x45; then return to IDLE.
REQ-028 SHALL ignore rx bytes that complete during BUS or RESP (no queuing).
REQ-029 SHALL keep req_o low outside BUS.
REQ-030 SHALL ignore ack_i while req_o is low.

Reset
REQ-031 SHALL, with reset_n low at an edge, set tx=1, req_o=0, rw_o=1, ds_o=0, addr_o=0, data_write_o=0, and busy=0.
REQ-032 SHALL, on that same reset edge, return all FSMs to idle and clear the baud counters.
REQ-033 SHALL abort any frame in progress when reset occurs mid-frame.
REQ-034 SHALL drop req_o on the reset edge when reset occurs mid-bus-cycle, and SHALL send no response.

Structure
REQ-035 SHALL place TICK default, command codes 0x52/0x57, response codes 0x4B/0x45, timeout limits and the FSM state encoding in shared package uart_pkg.
REQ-036 SHALL implement serial framing (baud counters, byte RX, byte TX with valid/ready) in one sub-module, uart_phy.

Verification
REQ-037 SHALL cover read: rx 52 00 01 00, responder acks after 3 clocks with 0xBEEF -> addr_o=0x000100, rw_o=1, ds_o=11, tx bytes BE EF.
REQ-038 SHALL cover write: rx 57 12 34 56 A5 5A, ack after 1 clock -> addr_o=0x123456, rw_o=0, data_write_o=0xA55A, tx byte 4B.
REQ-039 SHALL cover bus timeout: read of 0xFFFFFE with no ack -> req_o high exactly 256 clocks, tx byte 45, busy then 0.
REQ-040 SHALL cover bad framing: 1-clock rx glitch (false start), then 0x52 with stop bit 0 -> FSM stays IDLE, no tx activity.
REQ-041 SHALL cover frame abort: rx 57 00 then 2^20+1 idle clocks -> IDLE, no req_o; a following valid read completes normally.
REQ-042 SHALL cover mid-cycle reset: reset_n low 1 clock during BUS -> req_o=0, tx=1 next cycle, no response byte sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART-to-parallel-bus master.
package uart_pkg;

  localparam int TICK_DEFAULT = 434;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h45;

  localparam int BYTE_TIMEOUT_CLKS = 1 << 20;
  localparam int BUS_TIMEOUT_CLKS  = 256;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} cmd_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_phy.sv
// Serial framing: byte receiver with false-start rejection and a
// valid/ready byte transmitter (1 start, 8 data LSB first, 2 stop).
module uart_phy import uart_pkg::*; #(
  parameter int TICK = TICK_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  logic [1:0]  rx_sync;
  logic        rx_s;
  rx_state_t   rx_state, rx_state_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_tick_half, rx_tick_full;

  logic [10:0] tx_shift;
  logic [3:0]  tx_bits;
  logic [15:0] tx_cnt;

  assign rx_s         = rx_sync[1];
  assign rx_tick_half = rx_cnt == 16'(TICK / 2 - 1);
  assign rx_tick_full = rx_cnt == 16'(TICK - 1);

  always_comb begin
    rx_state_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_state_next = RX_START;
      RX_START: if (rx_tick_half) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick_full && rx_bit == 3'd7) rx_state_next = RX_STOP;
      RX_STOP:  if (rx_tick_full) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  // The bit counter restarts at the start-bit midpoint so later samples land mid-bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rx};
      rx_state <= rx_state_next;
      rx_valid <= 1'b0;
      if (rx_state == RX_IDLE || rx_state != rx_state_next || rx_tick_full)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == RX_START)
        rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick_full) begin
        rx_data <= {rx_s, rx_data[7:1]};
        rx_bit  <= rx_bit + 3'd1;
      end
      if (rx_state == RX_STOP && rx_tick_full && rx_s)
        rx_valid <= 1'b1;
    end
  end

  assign tx_ready = tx_bits == 4'd0;
  assign tx       = tx_shift[0];

  // Shifting in ones means the line rests high once the frame is out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_shift <= '1;
      tx_bits  <= '0;
      tx_cnt   <= '0;
    end else if (tx_ready) begin
      tx_cnt <= '0;
      if (tx_valid) begin
        tx_shift <= {2'b11, tx_data, 1'b0};
        tx_bits  <= 4'd11;
      end
    end else if (tx_cnt == 16'(TICK - 1)) begin
      tx_cnt   <= '0;
      tx_shift <= {1'b1, tx_shift[10:1]};
      tx_bits  <= tx_bits - 4'd1;
    end else begin
      tx_cnt <= tx_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Serial command interpreter driving a 16-bit request/acknowledge bus:
// 'R' a2 a1 a0 reads, 'W' a2 a1 a0 d1 d0 writes, with a serial status reply.
module uart_bus_master import uart_pkg::*; #(
  parameter int TICK         = TICK_DEFAULT,
  parameter int BYTE_TIMEOUT = BYTE_TIMEOUT_CLKS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        tx,
  output logic [23:0] addr_o,
  output logic [15:0] data_write_o,
  input  logic [15:0] data_read_i,
  output logic [1:0]  ds_o,
  output logic        rw_o,
  output logic        req_o,
  input  logic        ack_i,
  output logic        busy
);

  cmd_state_t  state, state_next;
  logic [7:0]  rx_data, tx_data;
  logic        rx_valid, tx_valid, tx_ready;
  logic [1:0]  byte_cnt;
  logic [20:0] wait_cnt;
  logic [7:0]  bus_cnt;
  logic        err;
  logic [15:0] rd_data;
  logic [1:0]  resp_left;
  logic        byte_timeout, bus_timeout, bus_done;

  uart_phy #(.TICK(TICK)) u_phy (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .tx       (tx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  assign busy         = state != IDLE;
  assign byte_timeout = wait_cnt == 21'(BYTE_TIMEOUT);
  assign bus_timeout  = bus_cnt == 8'(BUS_TIMEOUT_CLKS - 1);
  assign bus_done     = req_o && (ack_i || bus_timeout);

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = RESP_OK;
    case (state)
      IDLE: if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) state_next = ADDR;
      ADDR: begin
        if (byte_timeout) state_next = IDLE;
        else if (rx_valid && byte_cnt == 2'd2) state_next = rw_o ? BUS : DATA;
      end
      DATA: begin
        if (byte_timeout) state_next = IDLE;
        else if (rx_valid && byte_cnt == 2'd1) state_next = BUS;
      end
      BUS: if (bus_done) state_next = RESP;
      RESP: begin
        tx_valid = resp_left != 2'd0;
        if (err) tx_data = RESP_ERR;
        else if (rw_o) tx_data = (resp_left == 2'd2) ? rd_data[15:8] : rd_data[7:0];
        if (resp_left == 2'd0 && tx_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      req_o        <= 1'b0;
      rw_o         <= 1'b1;
      ds_o         <= 2'b00;
      addr_o       <= '0;
      data_write_o <= '0;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
      bus_cnt      <= '0;
      err          <= 1'b0;
      rd_data      <= '0;
      resp_left    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (rx_valid || state_next != state) ? '0 : wait_cnt + 21'd1;
      case (state)
        IDLE: if (state_next == ADDR) rw_o <= rx_data == CMD_READ;
        ADDR: if (rx_valid) begin
          addr_o   <= {addr_o[15:0], rx_data};
          byte_cnt <= byte_cnt + 2'd1;
        end
        DATA: if (rx_valid) begin
          data_write_o <= {data_write_o[7:0], rx_data};
          byte_cnt     <= byte_cnt + 2'd1;
        end
        BUS: begin
          if (bus_done) begin
            req_o     <= 1'b0;
            ds_o      <= 2'b00;
            err       <= !ack_i;
            resp_left <= (ack_i && rw_o) ? 2'd2 : 2'd1;
            if (ack_i && rw_o) rd_data <= data_read_i;
          end else begin
            bus_cnt <= bus_cnt + 8'd1;
          end
        end
        RESP: if (tx_valid && tx_ready) resp_left <= resp_left - 2'd1;
        default: ;
      endcase
      if (state_next != state) byte_cnt <= '0;
      // Request rises on the same edge the FSM enters BUS.
      if (state != BUS && state_next == BUS) begin
        req_o   <= 1'b1;
        ds_o    <= 2'b11;
        bus_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: serial commands in, bus responder,
// serial reply decoder, checked against a transaction-level expectation model.
module tb_uart_bus_master;

  localparam int TICK    = 16;
  localparam int BYTE_TO = 1000;

  logic        clk, reset_n, rx, tx, rw_o, req_o, ack_i, busy;
  logic [23:0] addr_o;
  logic [15:0] data_write_o, data_read_i;
  logic [1:0]  ds_o;

  int vectors     = 0;
  int miscompares = 0;

  int          ack_delay = -1;
  logic [15:0] rd_value  = '0;
  int          bus_cycles = 0;
  int          req_len    = 0;
  bit          stable_ok  = 1'b1;
  logic [23:0] cyc_addr   = '0;
  logic        cyc_rw     = 1'b0;
  logic [1:0]  cyc_ds     = '0;
  logic [15:0] cyc_wdata  = '0;

  logic [7:0] tx_q[$];
  logic [7:0] want_q[$];
  int         tx_frame_errs = 0;

  uart_bus_master #(.TICK(TICK), .BYTE_TIMEOUT(BYTE_TO)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .tx           (tx),
    .addr_o       (addr_o),
    .data_write_o (data_write_o),
    .data_read_i  (data_read_i),
    .ds_o         (ds_o),
    .rw_o         (rw_o),
    .req_o        (req_o),
    .ack_i        (ack_i),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bus responder: acknowledges ack_delay clocks after req rises (never if negative).
  initial begin : responder
    ack_i       = 1'b0;
    data_read_i = '0;
    forever begin
      @(negedge clk);
      if (req_o === 1'b1) begin
        bus_cycles++;
        req_len   = 0;
        stable_ok = 1'b1;
        cyc_addr  = addr_o;
        cyc_rw    = rw_o;
        cyc_ds    = ds_o;
        cyc_wdata = data_write_o;
        while (req_o === 1'b1) begin
          if (addr_o !== cyc_addr || rw_o !== cyc_rw || data_write_o !== cyc_wdata || ds_o !== 2'b11)
            stable_ok = 1'b0;
          if (ack_delay >= 0 && req_len == ack_delay) begin
            ack_i       = 1'b1;
            data_read_i = rd_value;
          end
          req_len++;
          @(negedge clk);
        end
        ack_i       = 1'b0;
        data_read_i = 16'($urandom);
      end
    end
  end

  // Serial decoder for the reply line.
  initial begin : tx_monitor
    logic [7:0] b;
    logic       s1, s2;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (TICK / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (TICK) @(negedge clk);
          b[i] = tx;
        end
        repeat (TICK) @(negedge clk);
        s1 = tx;
        repeat (TICK) @(negedge clk);
        s2 = tx;
        tx_q.push_back(b);
        if (!(s1 === 1'b1 && s2 === 1'b1)) tx_frame_errs++;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (TICK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (TICK) @(negedge clk);
    end
    rx = stop_ok;
    repeat (TICK) @(negedge clk);
    rx = 1'b1;
    repeat (TICK) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && busy !== 1'b0; i++) @(negedge clk);
    check_output("idle_wait", {31'b0, busy}, 32'd0);
  endtask

  // Expected reply derived from the command outcome alone.
  task automatic model_response(input bit is_read, input bit acked, input logic [15:0] rv);
    want_q.delete();
    if (!acked) want_q.push_back(8'h45);
    else if (is_read) begin
      want_q.push_back(rv[15:8]);
      want_q.push_back(rv[7:0]);
    end else want_q.push_back(8'h4B);
  endtask

  task automatic check_response();
    check_output("tx_count", tx_q.size(), want_q.size());
    foreach (want_q[i])
      check_output("tx_byte", (i < tx_q.size()) ? {24'b0, tx_q[i]} : 32'hFFFF_FFFF, {24'b0, want_q[i]});
    check_output("tx_framing", tx_frame_errs, 0);
  endtask

  task automatic apply_stimulus(input bit is_read, input logic [23:0] a, input logic [15:0] wd,
                                input int delay, input logic [15:0] rv);
    int cycles_before;
    cycles_before = bus_cycles;
    ack_delay     = delay;
    rd_value      = rv;
    tx_q.delete();
    model_response(is_read, delay >= 0, rv);
    send_byte(is_read ? 8'h52 : 8'h57, 1'b1);
    send_byte(a[23:16], 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(a[7:0], 1'b1);
    if (!is_read) begin
      send_byte(wd[15:8], 1'b1);
      send_byte(wd[7:0], 1'b1);
    end
    wait_idle(4000);
    check_output("bus_cycles", bus_cycles, cycles_before + 1);
    check_output("addr_o", {8'b0, cyc_addr}, {8'b0, a});
    check_output("rw_o", {31'b0, cyc_rw}, {31'b0, is_read});
    check_output("ds_o", {30'b0, cyc_ds}, 32'd3);
    check_output("bus_stable", {31'b0, stable_ok}, 32'd1);
    if (!is_read) check_output("data_write_o", {16'b0, cyc_wdata}, {16'b0, wd});
    check_output("req_len", req_len, (delay >= 0) ? delay + 1 : 256);
    check_response();
  endtask

  initial begin : stimulus
    int          cycles_before;
    logic [7:0]  noise;
    logic [23:0] ra;

    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_tx", {31'b0, tx}, 32'd1);
    check_output("rst_req", {31'b0, req_o}, 32'd0);
    check_output("rst_rw", {31'b0, rw_o}, 32'd1);
    check_output("rst_ds", {30'b0, ds_o}, 32'd0);
    check_output("rst_addr", {8'b0, addr_o}, 32'd0);
    check_output("rst_wdata", {16'b0, data_write_o}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed read, write and bus timeout");
    apply_stimulus(1'b1, 24'h000100, 16'h0000, 3, 16'hBEEF);
    apply_stimulus(1'b0, 24'h123456, 16'hA55A, 1, 16'h0000);
    apply_stimulus(1'b1, 24'hFFFFFE, 16'h0000, -1, 16'h0000);

    $display("[TB] false start and bad stop bit");
    cycles_before = bus_cycles;
    tx_q.delete();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (2 * TICK) @(negedge clk);
    send_byte(8'h52, 1'b0);
    repeat (4 * TICK) @(negedge clk);
    check_output("badframe_busy", {31'b0, busy}, 32'd0);
    check_output("badframe_tx", tx_q.size(), 0);
    check_output("badframe_bus", bus_cycles, cycles_before);

    $display("[TB] byte timeout abort");
    cycles_before = bus_cycles;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    check_output("abort_busy_mid", {31'b0, busy}, 32'd1);
    repeat (BYTE_TO + 50) @(negedge clk);
    check_output("abort_busy", {31'b0, busy}, 32'd0);
    check_output("abort_bus", bus_cycles, cycles_before);
    check_output("abort_tx", tx_q.size(), 0);
    apply_stimulus(1'b1, 24'($urandom), 16'h0000, 2, 16'($urandom));

    $display("[TB] randomized transactions");
    for (int n = 0; n < 6; n++) begin
      noise = 8'($urandom_range(0, 255));
      if (noise == 8'h52 || noise == 8'h57) noise = 8'h00;
      send_byte(noise, 1'b1);
      apply_stimulus(1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom),
                     int'($urandom_range(0, 5)), 16'($urandom));
    end

    $display("[TB] reset during bus cycle");
    ack_delay = -1;
    tx_q.delete();
    ra = 24'($urandom);
    send_byte(8'h52, 1'b1);
    send_byte(ra[23:16], 1'b1);
    send_byte(ra[15:8], 1'b1);
    send_byte(ra[7:0], 1'b1);
    for (int i = 0; i < 500 && req_o !== 1'b1; i++) @(negedge clk);
    check_output("midrst_req_seen", {31'b0, req_o}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("midrst_req", {31'b0, req_o}, 32'd0);
    check_output("midrst_tx", {31'b0, tx}, 32'd1);
    check_output("midrst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    repeat (3 * 11 * TICK) @(negedge clk);
    check_output("midrst_no_resp", tx_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
